// File: rtl/ddr_pkg.sv
// Shared types for the DDR arrow lanes: round state encoding and the LFSR polynomial.
package ddr_pkg;

   typedef enum logic [2:0] {IDLE, CLEAR, PLAY, PAUSE, DRAIN, DONE} state_e;

   // x^8+x^6+x^5+x^4+1 expressed as a mask over a left-shifting register
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   function automatic logic [7:0] lfsr8_next(input logic [7:0] v);
      return {v[6:0], ^(v & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/ddr_lfsr8.sv
// 8-bit Fibonacci LFSR with synchronous load; shared by the scheduler and later scoring logic.
module ddr_lfsr8
   import ddr_pkg::*;
#(
   parameter logic [7:0] RESET_VAL = 8'hA5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       adv,
   input  logic [7:0] seed,
   output logic [7:0] q
);

   logic [7:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (load)
         q_d = seed;
      else if (adv)
         q_d = lfsr8_next(q_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         q_q <= RESET_VAL;
      else
         q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/arrow_lane_scheduler.sv
// Round sequencer for the DDR arrow lanes: step strobe, one-hot spawn word, clear/busy/done.
// Optional build macro SPEEDUP_EN shortens the step divisor as the round progresses.
module arrow_lane_scheduler
   import ddr_pkg::*;
#(
   parameter int unsigned LANES       = 4,
   parameter int unsigned TICK_DIV    = 8,
   parameter int unsigned MIN_GAP     = 1,
   parameter int unsigned ARROWS      = 16,
   parameter int unsigned LANE_DEPTH  = 8,
   parameter logic [7:0]  LFSR_SEED   = 8'hA5,
   parameter int unsigned SPEED_EVERY = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         pause,
   output logic                         step,
   output logic [LANES-1:0]             spawn,
   output logic                         clear,
   output logic                         busy,
   output logic                         done,
   output logic [$clog2(ARROWS+1)-1:0]  arrows_left,
   output state_e                       dbg_state
);

   localparam int LW = $clog2(LANES);
   localparam int AW = $clog2(ARROWS + 1);
   localparam int TW = $clog2(TICK_DIV + 1);
   localparam int GW = $clog2(MIN_GAP + 2);
   localparam int DW = $clog2(LANE_DEPTH + 1);

   localparam logic [AW-1:0]    ARROWS_INIT = AW'(ARROWS);
   localparam logic [TW-1:0]    DIV_INIT    = TW'(TICK_DIV);
   localparam logic [GW-1:0]    GAP_INIT    = GW'(MIN_GAP);
   localparam logic [DW-1:0]    DRAIN_LAST  = DW'(LANE_DEPTH);
   localparam logic [LANES-1:0] LANE_ONE    = LANES'(1);

   state_e            state_q, state_d;
   logic [TW-1:0]     tick_q, tick_d;
   logic [GW-1:0]     gap_q, gap_d;
   logic [DW-1:0]     drain_q, drain_d;
   logic [AW-1:0]     arrows_q, arrows_d;
   logic              step_q, step_d;
   logic [LANES-1:0]  spawn_q, spawn_d;
   logic              clear_q, clear_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              lfsr_load, lfsr_adv, reload, spawn_evt;
   logic [7:0]        lfsr_val;
   logic [TW-1:0]     div;

   ddr_lfsr8 #(.RESET_VAL(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (lfsr_load),
      .adv   (lfsr_adv),
      .seed  (LFSR_SEED),
      .q     (lfsr_val)
   );

`ifdef SPEEDUP_EN
   localparam int SW = $clog2(SPEED_EVERY + 1);
   localparam logic [SW-1:0] SPD_LAST = SW'(SPEED_EVERY - 1);
   localparam logic [TW-1:0] DIV_MIN  = TW'(2);

   logic [TW-1:0] div_q, div_d;
   logic [SW-1:0] spd_q, spd_d;

   // Divisor only changes on a spawn, which is always a tick wrap, so tick is 0 here
   always_comb begin
      div_d = div_q;
      spd_d = spd_q;
      if (reload) begin
         div_d = DIV_INIT;
         spd_d = '0;
      end else if (spawn_evt) begin
         if (spd_q == SPD_LAST) begin
            spd_d = '0;
            if (div_q > DIV_MIN)
               div_d = div_q - 1'b1;
         end else begin
            spd_d = spd_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= DIV_INIT;
         spd_q <= '0;
      end else begin
         div_q <= div_d;
         spd_q <= spd_d;
      end
   end

   assign div = div_q;
`else
   assign div = DIV_INIT;

   logic unused_speedup;
   assign unused_speedup = ^{SPEED_EVERY, reload, spawn_evt};
`endif

   always_comb begin
      state_d   = state_q;
      tick_d    = tick_q;
      gap_d     = gap_q;
      drain_d   = drain_q;
      arrows_d  = arrows_q;
      step_d    = 1'b0;
      spawn_d   = '0;
      clear_d   = 1'b0;
      lfsr_load = 1'b0;
      lfsr_adv  = 1'b0;
      reload    = 1'b0;
      spawn_evt = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = CLEAR;
               clear_d = 1'b1;
            end
         end
         CLEAR: begin
            state_d   = PLAY;
            reload    = 1'b1;
            lfsr_load = 1'b1;
            arrows_d  = ARROWS_INIT;
            tick_d    = '0;
            gap_d     = '0;
            drain_d   = '0;
         end
         PLAY, PAUSE, DRAIN: begin
            if (state_q == DRAIN && drain_q == DRAIN_LAST) begin
               state_d = DONE;
            end else if (pause) begin
               state_d = PAUSE;
            end else begin
               // A released PAUSE behaves as PLAY/DRAIN in the same cycle, so a held terminal count fires now
               if (tick_q == div - 1'b1) begin
                  tick_d   = '0;
                  step_d   = 1'b1;
                  lfsr_adv = 1'b1;
                  if (gap_q == '0 && arrows_q != '0) begin
                     spawn_d   = LANE_ONE << lfsr_val[LW-1:0];
                     arrows_d  = arrows_q - 1'b1;
                     gap_d     = GAP_INIT;
                     spawn_evt = 1'b1;
                  end else begin
                     if (gap_q != '0)
                        gap_d = gap_q - 1'b1;
                     if (arrows_q == '0)
                        drain_d = drain_q + 1'b1;
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
               state_d = (arrows_d == '0) ? DRAIN : PLAY;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == CLEAR) || (state_d == PLAY) || (state_d == PAUSE) || (state_d == DRAIN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         tick_q   <= '0;
         gap_q    <= '0;
         drain_q  <= '0;
         arrows_q <= ARROWS_INIT;
         step_q   <= 1'b0;
         spawn_q  <= '0;
         clear_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         tick_q   <= tick_d;
         gap_q    <= gap_d;
         drain_q  <= drain_d;
         arrows_q <= arrows_d;
         step_q   <= step_d;
         spawn_q  <= spawn_d;
         clear_q  <= clear_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   logic unused_lfsr_hi;
   assign unused_lfsr_hi = ^lfsr_val[7:LW];

   assign step        = step_q;
   assign spawn       = spawn_q;
   assign clear       = clear_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign arrows_left = arrows_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_arrow_lane_scheduler.sv
// Bench for arrow_lane_scheduler: round-level model plus directed rounds with pause, stray start and mid-drain reset.
module tb_arrow_lane_scheduler;

   localparam int DIV        = 4;
   localparam int GAP        = 1;
   localparam int NA         = 3;
   localparam int DEP        = 2;
   localparam int NL         = 4;
   localparam int LAST_SPAWN = 1 + (NA - 1) * (GAP + 1);
   localparam int LAST_STEP  = LAST_SPAWN + DEP;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          pause = 1'b0;
   logic          step;
   logic [NL-1:0] spawn;
   logic          clear, busy, done;
   logic [1:0]    arrows_left;
   ddr_pkg::state_e dbg_state;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   logic [7:0]    exp_q[$];
   logic [NL-1:0] spn_q[$];

   arrow_lane_scheduler #(
      .LANES(NL), .TICK_DIV(DIV), .MIN_GAP(GAP), .ARROWS(NA),
      .LANE_DEPTH(DEP), .LFSR_SEED(8'hA5), .SPEED_EVERY(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .pause(pause),
      .step(step), .spawn(spawn), .clear(clear), .busy(busy), .done(done),
      .arrows_left(arrows_left), .dbg_state(dbg_state)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // round-level model: a round is a count of unpaused cycles; every DIV-th one is a step
   typedef struct {
      int            ph;      // 0 idle, 1 clear, 2 running, 3 done
      int            runs;
      int            steps;
      int            arrows;
      logic          st;
      logic [NL-1:0] sp;
      logic          cl;
   } mdl_t;

   mdl_t m;

   function automatic logic [NL-1:0] lane_word(input int n);
      logic [7:0] v;
      v = 8'hA5;
      for (int i = 1; i < n; i++)
         v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
      return NL'(1) << v[1:0];
   endfunction

   function automatic bit is_spawn_step(input int n);
      return (n >= 1) && (n <= LAST_SPAWN) && (((n - 1) % (GAP + 1)) == 0);
   endfunction

   function automatic mdl_t model_reset();
      mdl_t r;
      r.ph = 0; r.runs = 0; r.steps = 0; r.arrows = NA;
      r.st = 1'b0; r.sp = '0; r.cl = 1'b0;
      return r;
   endfunction

   function automatic mdl_t model_next(input mdl_t c, input logic st_in, input logic pa_in);
      mdl_t n;
      n = c;
      n.st = 1'b0; n.sp = '0; n.cl = 1'b0;
      case (c.ph)
         0, 3: if (st_in) begin n.ph = 1; n.cl = 1'b1; end
         1: begin n.ph = 2; n.runs = 0; n.steps = 0; n.arrows = NA; end
         2: begin
            if (c.steps == LAST_STEP) begin
               n.ph = 3;
            end else if (!pa_in) begin
               n.runs = c.runs + 1;
               if (n.runs % DIV == 0) begin
                  n.steps = c.steps + 1;
                  n.st = 1'b1;
                  if (is_spawn_step(n.steps)) begin
                     n.sp = lane_word(n.steps);
                     n.arrows = c.arrows - 1;
                  end
               end
            end
         end
         default: ;
      endcase
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= model_reset();
      else        m <= model_next(m, start, pause);
   end

   // scoreboard: every cycle against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("step", step, m.st);
         chk("spawn", spawn, m.sp);
         chk("clear", clear, m.cl);
         chk("arrows_left", arrows_left, m.arrows);
         chk("busy", busy, (m.ph == 1) || (m.ph == 2));
         chk("done", done, m.ph == 3);
         chk("spawn_onehot0", $onehot0(spawn), 1);
         chk("spawn_implies_step", (spawn == '0) || step, 1);
      end
   end

   // driver: one round; mode 0 stray start, 1 pauses, 2 reset mid-drain, 3 plain
   task automatic run_round(input int mode);
      int c0 = -1;
      int r = -1;
      int rr;
      bit fin = 1'b0;
      int done_r;
      done_r = (mode == 1) ? 43 : 30;
      exp_q.delete();
      spn_q.delete();
      case (mode)
         1:       exp_q = '{8'd5, 8'd19, 8'd23, 8'd30, 8'd34, 8'd38, 8'd42};
         2:       exp_q = '{8'd5, 8'd9, 8'd13, 8'd17, 8'd21, 8'd25};
         default: exp_q = '{8'd5, 8'd9, 8'd13, 8'd17, 8'd21, 8'd25, 8'd29};
      endcase
      spn_q = '{4'b0010, 4'b0010, 4'b0001};
      @(posedge clk);
      #1 start = 1'b1;
      for (int i = 0; i < 80 && !fin; i++) begin
         @(negedge clk);
         if (c0 < 0 && clear) c0 = cyc;
         r = (c0 < 0) ? -1 : cyc - c0;
         if (r >= 0) begin
            if (step) begin
               if (exp_q.size() == 0) chk("step_cycle_extra", r, 0);
               else                   chk("step_cycle", r, exp_q.pop_front());
            end
            if (spawn != '0) begin
               if (spn_q.size() == 0) chk("spawn_extra", spawn, 0);
               else                   chk("spawn_lane", spawn, spn_q.pop_front());
            end
            if (r == 4) chk("arrows_before_first_step", arrows_left, NA);
            if (done) begin
               chk("done_cycle", r, done_r);
               chk("busy_with_done", busy, 0);
               fin = 1'b1;
            end
            if (mode == 2 && r == 26) begin
               chk("state_before_reset", dbg_state, ddr_pkg::DRAIN);
               #1 rst_n = 1'b0;
               #1;
               chk("rst_step", step, 0);
               chk("rst_spawn", spawn, 0);
               chk("rst_clear", clear, 0);
               chk("rst_busy", busy, 0);
               chk("rst_done", done, 0);
               chk("rst_arrows_left", arrows_left, NA);
               chk("rst_state", dbg_state, ddr_pkg::IDLE);
               fin = 1'b1;
            end
         end
         if (!fin) begin
            @(posedge clk);
            #1;
            rr = (c0 < 0) ? -1 : cyc - c0;
            start = (mode == 0 && rr == 7);
            pause = (mode == 1) && ((rr >= 7 && rr <= 16) || (rr >= 26 && rr <= 28));
         end
      end
      start = 1'b0;
      pause = 1'b0;
      if (!fin) chk("round_timeout", 0, 1);
      if (mode != 2) chk("steps_missing", exp_q.size(), 0);
      chk("spawns_missing", spn_q.size(), 0);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_step", step, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_arrows_left", arrows_left, NA);
      chk("reset_state", dbg_state, ddr_pkg::IDLE);
      #1 rst_n = 1'b1;
      chk_en = 1'b1;

      chk("model_lane_step1", lane_word(1), 4'b0010);
      chk("model_lane_step3", lane_word(3), 4'b0010);
      chk("model_lane_step5", lane_word(5), 4'b0001);
      chk("model_gap_step2", is_spawn_step(2), 0);
      chk("model_no_spawn_step7", is_spawn_step(7), 0);

      run_round(0);
      run_round(1);
      run_round(2);
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1 rst_n = 1'b1;
      run_round(3);
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("idle_after_rounds_busy", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion before 100000");
      $fatal(1, "watchdog");
   end

endmodule
